// File: rtl/prio_pkg.sv
// Shared definitions for the registered priority encoder.
package prio_pkg;

  // Values for the LSB_FIRST parameter.
  localparam int PRIO_MSB = 0;  // highest set index wins
  localparam int PRIO_LSB = 1;  // lowest set index wins

  // Ceiling log2, never less than 1 so a 2-input encoder still gets a 1-bit index.
  function automatic int f_clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage : prio_pkg

// File: rtl/prio_pick.sv
// Combinational winner picker: index, one-hot of the winner, any-set and more-than-one-set flags.
module prio_pick
  import prio_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int LSB_FIRST = PRIO_MSB,
  localparam int IDX_W     = f_clog2(N)
) (
  input  logic [N-1:0]     v,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             any,
  output logic             multi
);

  // Scan so the last hit overwrites earlier ones: ascending finds the highest bit, descending the lowest.
  // NOTE: every variable written in always_comb gets a default first; otherwise a path that skips the
  // assignment keeps the old value and a latch is inferred.
  always_comb begin
    idx    = '0;
    onehot = '0;
    if (LSB_FIRST == PRIO_LSB) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (v[i]) begin
          idx       = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (v[i]) begin
          idx       = IDX_W'(i);
          onehot    = '0;
          onehot[i] = 1'b1;
        end
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more bits were set.
  assign any   = |v;
  assign multi = |(v & (v - N'(1)));

endmodule : prio_pick

// File: rtl/prio_encoder_q.sv
// Registered priority encoder: sticky pending capture, one index issued per valid/ready handshake.
module prio_encoder_q
  import prio_pkg::*;
#(
  parameter  int N         = 8,
  parameter  int LSB_FIRST = PRIO_MSB,
  localparam int IDX_W     = f_clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_multi,
  output logic [N-1:0]     pending,
  output logic             busy
);

  logic [N-1:0]     pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic             out_multi_q, out_multi_d;

  logic [N-1:0]     set_mask;
  logic [N-1:0]     clr_mask;
  logic             free;
  logic             load;

  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     pick_onehot;
  logic             pick_any;
  logic             pick_multi;

  // Selection looks only at the registered pending vector, never at same-cycle req.
  prio_pick #(
    .N         (N),
    .LSB_FIRST (LSB_FIRST)
  ) u_pick (
    .v      (pending_q),
    .idx    (pick_idx),
    .onehot (pick_onehot),
    .any    (pick_any),
    .multi  (pick_multi)
  );

  assign set_mask = req & {N{en}};
  assign free     = !out_valid_q || out_ready;
  assign load     = free && pick_any;
  assign clr_mask = load ? pick_onehot : '0;

  // Next state: clear the issued bit, then OR in new requests so a same-edge re-request wins.
  always_comb begin
    pending_d   = (pending_q & ~clr_mask) | set_mask;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_multi_d = out_multi_q;
    if (free) begin
      out_valid_d = pick_any;
      if (pick_any) begin
        out_idx_d   = pick_idx;
        out_multi_d = pick_multi;
      end
    end
  end

  // State registers with synchronous active-low reset that discards everything in flight.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_multi_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_multi_q <= out_multi_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_multi = out_multi_q;
  assign pending   = pending_q;
  assign busy      = out_valid_q | (|pending_q);

endmodule : prio_encoder_q

// File: tb/tb_prio_encoder_q.sv
// Bench for prio_encoder_q: three configurations (N=8 MSB-first, N=8 LSB-first, N=5 MSB-first)
// driven in lockstep and compared every cycle against an arithmetic reference model.
module tb_prio_encoder_q;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_v;
  logic       en_v;
  logic       rdy_v;

  always #5 clk = ~clk;

  logic [7:0] pend0, pend1;
  logic [4:0] pend2;
  logic [2:0] idx0, idx1, idx2;
  logic       val0, val1, val2;
  logic       mul0, mul1, mul2;
  logic       bsy0, bsy1, bsy2;

  prio_encoder_q #(.N(8), .LSB_FIRST(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req_v), .en(en_v), .out_valid(val0), .out_ready(rdy_v),
    .out_idx(idx0), .out_multi(mul0), .pending(pend0), .busy(bsy0));

  prio_encoder_q #(.N(8), .LSB_FIRST(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req(req_v), .en(en_v), .out_valid(val1), .out_ready(rdy_v),
    .out_idx(idx1), .out_multi(mul1), .pending(pend1), .busy(bsy1));

  prio_encoder_q #(.N(5), .LSB_FIRST(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req(req_v[4:0]), .en(en_v), .out_valid(val2), .out_ready(rdy_v),
    .out_idx(idx2), .out_multi(mul2), .pending(pend2), .busy(bsy2));

  logic [63:0] g_pend  [3];
  logic [63:0] g_idx   [3];
  logic        g_valid [3];
  logic        g_multi [3];
  logic        g_busy  [3];

  assign g_pend[0] = 64'(pend0);  assign g_pend[1] = 64'(pend1);  assign g_pend[2] = 64'(pend2);
  assign g_idx[0]  = 64'(idx0);   assign g_idx[1]  = 64'(idx1);   assign g_idx[2]  = 64'(idx2);
  assign g_valid[0] = val0;       assign g_valid[1] = val1;       assign g_valid[2] = val2;
  assign g_multi[0] = mul0;       assign g_multi[1] = mul1;       assign g_multi[2] = mul2;
  assign g_busy[0]  = bsy0;       assign g_busy[1]  = bsy1;       assign g_busy[2]  = bsy2;

  localparam int NN [3] = '{8, 8, 5};
  localparam int LF [3] = '{0, 1, 0};

  // Reference model state, one entry per configuration.
  longint unsigned m_pend  [3];
  longint unsigned m_idx   [3];
  bit              m_valid [3];
  bit              m_multi [3];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Winner index from arithmetic: highest bit = clog2(p+1)-1, lowest bit = log2 of (p & -p).
  function automatic longint unsigned winner(input longint unsigned p, input int lsb_first);
    if (lsb_first != 0) return longint'($clog2(p & (~p + 1)));
    return longint'($clog2(p + 1) - 1);
  endfunction

  // Advance the model over one edge using current inputs, take the edge, then compare all outputs.
  task automatic step();
    for (int i = 0; i < 3; i++) begin
      longint unsigned mask, set, k;
      bit free;
      mask = (64'd1 << NN[i]) - 1;
      set  = en_v ? (64'(req_v) & mask) : 64'd0;
      free = !m_valid[i] || rdy_v;
      if (!rst_n) begin
        m_pend[i] = 0; m_valid[i] = 0; m_idx[i] = 0; m_multi[i] = 0;
      end else if (free && m_pend[i] != 0) begin
        k          = winner(m_pend[i], LF[i]);
        m_multi[i] = $countones(m_pend[i]) > 1;
        m_idx[i]   = k;
        m_valid[i] = 1;
        m_pend[i]  = (m_pend[i] & ~(64'd1 << k)) | set;
      end else begin
        if (free) m_valid[i] = 0;
        m_pend[i] = m_pend[i] | set;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pending[%0d]", i),   g_pend[i],  m_pend[i]);
      check($sformatf("out_valid[%0d]", i), 64'(g_valid[i]), 64'(m_valid[i]));
      check($sformatf("out_idx[%0d]", i),   g_idx[i],   m_idx[i]);
      check($sformatf("out_multi[%0d]", i), 64'(g_multi[i]), 64'(m_multi[i]));
      check($sformatf("busy[%0d]", i),      64'(g_busy[i]),
            64'(m_valid[i] || (m_pend[i] != 0)));
    end
  endtask

  task automatic idle(input int n);
    req_v = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  int sevens;

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0; m_idx[i] = 0; m_valid[i] = 0; m_multi[i] = 0;
    end
    rst_n = 1'b0; req_v = 8'hFF; en_v = 1'b1; rdy_v = 1'b1;

    // Reset holds everything clear even with all requests asserted.
    for (int c = 0; c < 3; c++) begin
      step();
      check("rst_pending", g_pend[0], 64'd0);
      check("rst_valid",   64'(g_valid[0]), 64'd0);
      check("rst_idx",     g_idx[0], 64'd0);
      check("rst_busy",    64'(g_busy[0]), 64'd0);
    end
    // First sampled request after release: captured, then issued one edge later.
    rst_n = 1'b1;
    step();
    check("rel_valid_t1", 64'(g_valid[0]), 64'd0);
    req_v = 8'h00;
    step();
    check("rel_valid_t2", 64'(g_valid[0]), 64'd1);
    check("rel_idx_t2",   g_idx[0], 64'd7);
    idle(10);

    // Single hit.
    req_v = 8'h20;
    step();
    check("single_t1_valid", 64'(g_valid[0]), 64'd0);
    req_v = 8'h00;
    step();
    check("single_valid", 64'(g_valid[0]), 64'd1);
    check("single_idx",   g_idx[0], 64'd5);
    check("single_multi", 64'(g_multi[0]), 64'd0);
    check("single_pend",  g_pend[0], 64'd0);
    step();
    check("single_done", 64'(g_valid[0]), 64'd0);
    idle(2);

    // Multi-hit ordering in both directions.
    req_v = 8'h91;
    step();
    req_v = 8'h00;
    step();
    check("multi_msb_0", g_idx[0], 64'd7); check("multi_msb_m0", 64'(g_multi[0]), 64'd1);
    check("multi_lsb_0", g_idx[1], 64'd0); check("multi_lsb_m0", 64'(g_multi[1]), 64'd1);
    step();
    check("multi_msb_1", g_idx[0], 64'd4); check("multi_msb_m1", 64'(g_multi[0]), 64'd1);
    check("multi_lsb_1", g_idx[1], 64'd4);
    step();
    check("multi_msb_2", g_idx[0], 64'd0); check("multi_msb_m2", 64'(g_multi[0]), 64'd0);
    check("multi_lsb_2", g_idx[1], 64'd7); check("multi_lsb_m2", 64'(g_multi[1]), 64'd0);
    idle(3);

    // Backpressure holds the issued index stable.
    rdy_v = 1'b0;
    req_v = 8'h0C;
    step();
    req_v = 8'h00;
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_idx",   g_idx[0], 64'd3);
      check("bp_multi", 64'(g_multi[0]), 64'd1);
      check("bp_valid", 64'(g_valid[0]), 64'd1);
    end
    rdy_v = 1'b1;
    step();
    check("bp_next_idx", g_idx[0], 64'd2);
    step();
    check("bp_drained", 64'(g_valid[0]), 64'd0);
    idle(2);

    // Set-wins collision: re-request on the loading edge issues the bit twice; with en=0 once.
    for (int variant = 0; variant < 2; variant++) begin
      sevens = 0;
      req_v = 8'h80; en_v = 1'b1;
      step();
      en_v = (variant == 0);
      step();
      if (g_valid[0] && g_idx[0] == 3'd7) sevens++;
      en_v = 1'b1; req_v = 8'h00;
      for (int c = 0; c < 4; c++) begin
        step();
        if (g_valid[0] && g_idx[0] == 3'd7) sevens++;
      end
      check($sformatf("collide_count_en%0d", 1 - variant), 64'(sevens), (variant == 0) ? 64'd2 : 64'd1);
    end

    // Reset mid-operation on the N=5 instance.
    rdy_v = 1'b0;
    req_v = 8'h16;
    step();
    step();
    check("mid_valid_pre", 64'(g_valid[2]), 64'd1);
    check("mid_idx_pre",   g_idx[2], 64'd4);
    check("mid_pend_pre",  g_pend[2], 64'h16);
    rst_n = 1'b0; req_v = 8'h00;
    step();
    check("mid_rst_pend",  g_pend[2], 64'd0);
    check("mid_rst_valid", 64'(g_valid[2]), 64'd0);
    rst_n = 1'b1; rdy_v = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check("mid_no_issue", 64'(g_valid[2]), 64'd0);
    end

    // Single-bit sweep: N=5 never reports an index above 4.
    for (int b = 0; b < 8; b++) begin
      req_v = 8'(1 << b);
      step();
      req_v = 8'h00;
      for (int c = 0; c < 3; c++) begin
        step();
        if (g_valid[2]) check("n5_idx_range", 64'(g_idx[2] <= 64'd4), 64'd1);
      end
    end

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      req_v = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      en_v  = ($urandom_range(0, 4) != 0);
      rdy_v = ($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 149) != 0);
      step();
      if (g_valid[2]) check("rand_n5_range", 64'(g_idx[2] <= 64'd4), 64'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_prio_encoder_q

// File: doc/prio_encoder_q.md
Name: prio_encoder_q

Overview:
Parametrised, registered priority encoder with request capture. It generalises the fixed 8-to-3 encoder to N inputs, with selectable priority direction and a valid/ready output handshake. Request bits are latched into a sticky pending vector. Indices are issued one at a time, winner first, and each issued bit is cleared from pending. It sits between interrupt/event sources and a consumer that services one index per handshake.

Parameters:
N, 8, number of request inputs (2..64).
IDX_W, $clog2(N), index width; derived localparam, not overridable.
LSB_FIRST, 0, priority direction: 0 = highest set index wins, 1 = lowest set index wins.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous, active-low reset.
req  input  N  request bits, sampled each clock when en=1.
en  input  1  capture enable; when 0, req is ignored.
out_valid  output  1  out_idx/out_multi hold a valid issued index.
out_ready  input  1  consumer accepts when out_valid & out_ready at a clock edge.
out_idx  output  IDX_W  issued index, binary.
out_multi  output  1  other pending bits existed when out_idx was loaded.
pending  output  N  current pending vector (registered).
busy  output  1  out_valid | (|pending), combinational from registers.

Behaviour:
- Reset is synchronous and active-low. On a clock edge with rst_n=0: pending=0, out_valid=0, out_idx=0, out_multi=0. Reset overrides every other event, including an in-flight handshake; captured requests are discarded.
- Capture: set_mask = req & {N{en}}, OR-ed into pending at each edge.
- Slot free: free = !out_valid | out_ready.
- Load: when free and pending != 0:
  - winner k = highest set bit of pending (LSB_FIRST=0) or lowest set bit (LSB_FIRST=1);
  - out_idx <= k, out_valid <= 1, out_multi <= (pending has more than one bit set);
  - pending[k] cleared at the same edge.
- Drain: when free and pending == 0, out_valid <= 0. out_idx and out_multi keep their last values.
- Hold: when out_valid & !out_ready, out_idx and out_multi are stable. Only pending may change (set_mask).
- Same-bit set/clear: set wins. If req[k]&en occurs on the edge where k is loaded, pending[k] stays 1 and k is issued again later.
- Selection sees only the registered pending, never same-cycle req.
  - Latency: req at edge t → pending at t+1 → out_valid at t+2 (slot free).
  - Throughput: one index per cycle with out_ready held high.
- Back-to-back: with out_ready=1 and a new winner present, out_valid stays high with no bubble.
- Duplicate suppression: a bit that is already pending and is re-requested before issue is issued once.
- N not a power of two: out_idx never exceeds N-1. Unused index codes are never produced.
- No X on outputs after reset. All outputs are registered except busy.

Decomposition:
- Shared package prio_pkg:
  - localparams PRIO_MSB=0, PRIO_LSB=1;
  - function f_clog2 for IDX_W.
- One sub-module, prio_pick: purely combinational, parameters N and LSB_FIRST.
  - Inputs: vector v.
  - Outputs: idx[IDX_W], onehot[N], any, multi.
  - Reused by the top for winner select and clear mask.
- Top holds the pending register, output slot and handshake logic.

Test Plan:
- Reset: drive req=8'hFF, en=1, rst_n=0 for 3 cycles → pending=0, out_valid=0, out_idx=0, busy=0 throughout. Release → out_valid rises 2 cycles after the first sampled req.
- Single hit (N=8, LSB_FIRST=0): req=8'h20 for one cycle, out_ready=1 → out_valid=1 for exactly one cycle, 2 cycles later; out_idx=5, out_multi=0, pending back to 0.
- Multi hit ordering: req=8'h91 once, out_ready=1:
  - LSB_FIRST=0 → out_idx sequence 7,4,0 on consecutive cycles, out_multi 1,1,0;
  - LSB_FIRST=1 → sequence 0,4,7.
- Backpressure: req=8'h0C, out_ready=0 for 5 cycles → out_idx=3, out_multi=1, stable. Assert out_ready → 3 then 2 issued, then out_valid=0.
- Set-wins collision: out_valid=1 with out_idx=6, out_ready=1, req=8'h80 (bit 7) and en=1 on the edge where 7 is loaded → 7 issued twice total; en=0 variant → issued once.
- Reset mid-operation and N=5: pending=5'b10110, out_valid=1, pull rst_n low one cycle → all cleared, no further issue. Sweep all single-bit req patterns → out_idx always within 0..4.
